// File: rtl/mem_bus_arbiter.sv
// Shared memory port arbiter: CPU strobes vs. DMA requester, one access at a time,
// WAIT extra memory cycles per access, and a starvation limit that forces a DMA slot.
module mem_bus_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int WAIT   = 1,
  parameter int STARVE = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Rbus,
  input  logic          Wbus,
  input  logic [AW-1:0] ADDRcpu,
  input  logic [DW-1:0] DINcpu,
  output logic [DW-1:0] DOUTcpu,
  output logic          ACKcpu,
  output logic          STALL,
  input  logic          REQdma,
  input  logic          WEdma,
  input  logic [AW-1:0] ADDRdma,
  input  logic [DW-1:0] DINdma,
  output logic [DW-1:0] DOUTdma,
  output logic          GNTdma,
  output logic          DONEdma,
  output logic          MEMen,
  output logic          MEMwe,
  output logic [AW-1:0] MEMaddr,
  output logic [DW-1:0] MEMdin,
  input  logic [DW-1:0] MEMdout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_V   = 4'(WAIT);
  localparam logic [3:0] STARVE_V = 4'(STARVE);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] starve_cnt;
  logic       owner;      // 1 = DMA owns the current access
  logic       cpu_req;
  logic       dma_sel;
  logic       cpu_sel;

  assign cpu_req = Rbus | Wbus;
  assign dma_sel = REQdma & (~cpu_req | (starve_cnt == STARVE_V));
  assign cpu_sel = cpu_req & ~dma_sel;
  assign STALL   = cpu_req & ~ACKcpu;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      starve_cnt <= 4'd0;
      owner      <= 1'b0;
      DOUTcpu    <= '0;
      DOUTdma    <= '0;
      ACKcpu     <= 1'b0;
      GNTdma     <= 1'b0;
      DONEdma    <= 1'b0;
      MEMen      <= 1'b0;
      MEMwe      <= 1'b0;
      MEMaddr    <= '0;
      MEMdin     <= '0;
    end else begin
      ACKcpu  <= 1'b0;
      DONEdma <= 1'b0;
      if (!REQdma) starve_cnt <= 4'd0;
      case (state)
        IDLE: begin
          // The MEM* registers double as the latched request, so later input
          // changes cannot disturb an access already granted.
          if (dma_sel) begin
            owner      <= 1'b1;
            MEMaddr    <= ADDRdma;
            MEMdin     <= DINdma;
            MEMwe      <= WEdma;
            MEMen      <= 1'b1;
            GNTdma     <= 1'b1;
            cnt        <= WAIT_V;
            starve_cnt <= 4'd0;
            state      <= ACCESS;
          end else if (cpu_sel) begin
            owner   <= 1'b0;
            MEMaddr <= ADDRcpu;
            MEMdin  <= DINcpu;
            MEMwe   <= Wbus;
            MEMen   <= 1'b1;
            cnt     <= WAIT_V;
            state   <= ACCESS;
            if (REQdma && starve_cnt != STARVE_V) starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            MEMen <= 1'b0;
            MEMwe <= 1'b0;
            if (!MEMwe) begin
              if (owner) DOUTdma <= MEMdout;
              else       DOUTcpu <= MEMdout;
            end
            if (owner) DONEdma <= 1'b1;
            else       ACKcpu  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          GNTdma <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: one arbiter with WAIT=1/STARVE=4 and a second with WAIT=0.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rbus, wbus, req_dma, we_dma;
  logic [15:0] addr_cpu, din_cpu, addr_dma, din_dma, mem_dout;
  logic [15:0] dout_cpu, dout_dma, mem_addr, mem_din;
  logic        ack_cpu, stall, gnt_dma, done_dma, mem_en, mem_we;

  logic        rbus_b, wbus_b, req_dma_b, we_dma_b;
  logic [15:0] addr_cpu_b, din_cpu_b, addr_dma_b, din_dma_b, mem_dout_b;
  logic [15:0] dout_cpu_b, dout_dma_b, mem_addr_b, mem_din_b;
  logic        ack_cpu_b, stall_b, gnt_dma_b, done_dma_b, mem_en_b, mem_we_b;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.AW(16), .DW(16), .WAIT(1), .STARVE(4)) dut (
    .CLK(clk), .RST(rst), .Rbus(rbus), .Wbus(wbus), .ADDRcpu(addr_cpu), .DINcpu(din_cpu),
    .DOUTcpu(dout_cpu), .ACKcpu(ack_cpu), .STALL(stall), .REQdma(req_dma), .WEdma(we_dma),
    .ADDRdma(addr_dma), .DINdma(din_dma), .DOUTdma(dout_dma), .GNTdma(gnt_dma),
    .DONEdma(done_dma), .MEMen(mem_en), .MEMwe(mem_we), .MEMaddr(mem_addr),
    .MEMdin(mem_din), .MEMdout(mem_dout)
  );

  mem_bus_arbiter #(.AW(16), .DW(16), .WAIT(0), .STARVE(4)) dut_b (
    .CLK(clk), .RST(rst), .Rbus(rbus_b), .Wbus(wbus_b), .ADDRcpu(addr_cpu_b), .DINcpu(din_cpu_b),
    .DOUTcpu(dout_cpu_b), .ACKcpu(ack_cpu_b), .STALL(stall_b), .REQdma(req_dma_b),
    .WEdma(we_dma_b), .ADDRdma(addr_dma_b), .DINdma(din_dma_b), .DOUTdma(dout_dma_b),
    .GNTdma(gnt_dma_b), .DONEdma(done_dma_b), .MEMen(mem_en_b), .MEMwe(mem_we_b),
    .MEMaddr(mem_addr_b), .MEMdin(mem_din_b), .MEMdout(mem_dout_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int        n_stall, n_men, n_gnt, n_done, ack_at, n_ev;
  logic [9:0] ev;

  initial begin
    rst = 1'b1;
    rbus = 0; wbus = 0; req_dma = 0; we_dma = 0;
    addr_cpu = 0; din_cpu = 0; addr_dma = 0; din_dma = 0; mem_dout = 0;
    rbus_b = 0; wbus_b = 0; req_dma_b = 0; we_dma_b = 0;
    addr_cpu_b = 0; din_cpu_b = 0; addr_dma_b = 0; din_dma_b = 0; mem_dout_b = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset / idle state
    samp();
    chk("rst_ack", ack_cpu, 0);
    chk("rst_gnt", gnt_dma, 0);
    chk("rst_done", done_dma, 0);
    chk("rst_men", mem_en, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdin", mem_din, 0);
    chk("rst_dcpu", dout_cpu, 0);
    chk("rst_ddma", dout_dma, 0);
    chk("rst_stall", stall, 0);
    chk("rst_men_b", mem_en_b, 0);
    tick();

    // CPU read, WAIT=1
    rbus = 1; addr_cpu = 16'h0010; mem_dout = 16'hBEEF;
    n_stall = 0; n_men = 0; ack_at = -1;
    for (int i = 0; i < 4; i++) begin
      samp();
      if (stall) n_stall++;
      if (mem_en) n_men++;
      if (ack_cpu) begin
        ack_at = i;
        chk("rd_dout", dout_cpu, 16'hBEEF);
      end
      if (i == 1) begin
        chk("rd_maddr", mem_addr, 16'h0010);
        chk("rd_mwe", mem_we, 0);
      end
      tick();
    end
    rbus = 0;
    chk("rd_stall_cycles", n_stall, 3);
    chk("rd_men_cycles", n_men, 2);
    chk("rd_ack_at", ack_at, 3);
    tick();

    // CPU write with both strobes; read register must not change
    rbus = 1; wbus = 1; addr_cpu = 16'h0020; din_cpu = 16'h1234; mem_dout = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      samp();
      if (i == 1 || i == 2) begin
        chk("wr_men", mem_en, 1);
        chk("wr_mwe", mem_we, 1);
        chk("wr_maddr", mem_addr, 16'h0020);
        chk("wr_mdin", mem_din, 16'h1234);
      end
      if (i == 3) begin
        chk("wr_ack", ack_cpu, 1);
        chk("wr_dout_kept", dout_cpu, 16'hBEEF);
        chk("wr_men_off", mem_en, 0);
      end
      tick();
    end
    rbus = 0; wbus = 0;
    tick();

    // DMA read with CPU idle
    req_dma = 1; we_dma = 0; addr_dma = 16'h0100; mem_dout = 16'h00AA;
    n_gnt = 0; n_done = 0;
    for (int i = 0; i < 4; i++) begin
      samp();
      if (gnt_dma) n_gnt++;
      if (done_dma) n_done++;
      if (i == 1) chk("dr_maddr", mem_addr, 16'h0100);
      if (i == 3) begin
        chk("dr_done_last", done_dma, 1);
        chk("dr_dout", dout_dma, 16'h00AA);
        chk("dr_dcpu_kept", dout_cpu, 16'hBEEF);
      end
      tick();
    end
    req_dma = 0;
    chk("dr_gnt_cycles", n_gnt, 3);
    chk("dr_done_cycles", n_done, 1);
    tick();

    // Starvation: continuous CPU and DMA requests -> 4 CPU, 1 DMA, repeated
    rbus = 1; addr_cpu = 16'h0030; req_dma = 1; addr_dma = 16'h0200; mem_dout = 16'h0042;
    ev = '0; n_ev = 0;
    for (int i = 0; i < 40; i++) begin
      samp();
      if (ack_cpu) begin ev = {ev[8:0], 1'b0}; n_ev++; end
      if (done_dma) begin ev = {ev[8:0], 1'b1}; n_ev++; end
      tick();
    end
    rbus = 0; req_dma = 0;
    chk("starve_events", n_ev, 10);
    chk("starve_order", ev, 10'b0000100001);
    tick();

    // Reset during the second ACCESS cycle of a DMA write
    req_dma = 1; we_dma = 1; addr_dma = 16'h0300; din_dma = 16'h7777;
    tick();
    samp();
    chk("ab_men", mem_en, 1);
    chk("ab_mwe", mem_we, 1);
    chk("ab_gnt", gnt_dma, 1);
    chk("ab_mdin", mem_din, 16'h7777);
    tick();
    rst = 1;
    samp();
    chk("ab_men2", mem_en, 1);
    tick();
    rst = 0;
    samp();
    chk("ab_men_off", mem_en, 0);
    chk("ab_gnt_off", gnt_dma, 0);
    chk("ab_no_done", done_dma, 0);
    chk("ab_mwe_off", mem_we, 0);
    tick();
    samp();
    chk("ab_regnt", gnt_dma, 1);
    chk("ab_regnt_men", mem_en, 1);
    chk("ab_regnt_nodone", done_dma, 0);
    tick();
    samp();
    chk("ab_acc2_nodone", done_dma, 0);
    tick();
    samp();
    chk("ab_done", done_dma, 1);
    tick();
    req_dma = 0; we_dma = 0;
    tick();

    // WAIT=0: DMA raised during CPU access gets the first IDLE after DONE
    rbus_b = 1; wbus_b = 1; addr_cpu_b = 16'h0040; din_cpu_b = 16'h4444;
    samp();
    chk("w0_stall", stall_b, 1);
    tick();
    req_dma_b = 1; we_dma_b = 1; addr_dma_b = 16'h0500; din_dma_b = 16'h5555;
    addr_cpu_b = 16'h0099; din_cpu_b = 16'h9999;
    samp();
    chk("w0_men", mem_en_b, 1);
    chk("w0_maddr", mem_addr_b, 16'h0040);
    chk("w0_mdin", mem_din_b, 16'h4444);
    chk("w0_gnt_low", gnt_dma_b, 0);
    tick();
    samp();
    chk("w0_ack", ack_cpu_b, 1);
    chk("w0_men_off", mem_en_b, 0);
    chk("w0_stall_off", stall_b, 0);
    tick();
    rbus_b = 0; wbus_b = 0;
    samp();
    chk("w0_idle_men", mem_en_b, 0);
    tick();
    samp();
    chk("w0_dgnt", gnt_dma_b, 1);
    chk("w0_dmen", mem_en_b, 1);
    chk("w0_dmaddr", mem_addr_b, 16'h0500);
    chk("w0_dmdin", mem_din_b, 16'h5555);
    tick();
    samp();
    chk("w0_ddone", done_dma_b, 1);
    chk("w0_dmen_off", mem_en_b, 0);
    tick();
    req_dma_b = 0; we_dma_b = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequencer and arbiter for the shared memory bus. The CPU control unit's Rbus/Wbus strobes and a DMA requester both contend for a single synchronous memory port. The block grants one access at a time and inserts a programmable number of wait states. It stalls the CPU program counter (gating PCpp) until the CPU access completes, and a starvation limit guarantees the DMA port a slot.

## Interface
- AW, 16, address width
- DW, 16, data width
- WAIT, 1, extra memory wait cycles per access (0..15)
- STARVE, 4, max consecutive CPU grants while DMA is pending (1..15)

Reset is synchronous and active-high.

- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  synchronous active-high reset
- Rbus  in  1  CPU read request, level, held until ACKcpu
- Wbus  in  1  CPU write request, level, held until ACKcpu
- ADDRcpu  in  AW  CPU address
- DINcpu  in  DW  CPU write data
- DOUTcpu  out  DW  CPU read data, valid while ACKcpu=1
- ACKcpu  out  1  one-cycle CPU completion pulse
- STALL  out  1  combinational: (Rbus|Wbus) & ~ACKcpu
- REQdma  in  1  DMA request, level, held until DONEdma
- WEdma  in  1  DMA write enable (1=write, 0=read)
- ADDRdma  in  AW  DMA address
- DINdma  in  DW  DMA write data
- DOUTdma  out  DW  DMA read data, valid while DONEdma=1
- GNTdma  out  1  DMA owns bus, grant cycle through DONE cycle
- DONEdma  out  1  one-cycle DMA completion pulse
- MEMen  out  1  memory enable, high for WAIT+1 cycles per access
- MEMwe  out  1  memory write enable, qualified by MEMen
- MEMaddr  out  AW  memory address
- MEMdin  out  DW  memory write data
- MEMdout  in  DW  memory read data, sampled on last MEMen cycle

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If a request is selected, latch owner, address, write data and we.
  - Load cnt=WAIT and go to ACCESS.
  - Otherwise stay in IDLE.
- Selection in IDLE:
  - DMA is chosen if REQdma=1 and either no CPU request is present or starve_cnt==STARVE.
  - Otherwise the CPU is chosen if Rbus|Wbus.
- CPU direction: Wbus=1 gives a write regardless of Rbus; Rbus alone gives a read.
- starve_cnt:
  - Increments on each CPU grant while REQdma=1, saturating at STARVE.
  - Clears on a DMA grant or whenever REQdma=0.
- ACCESS:
  - MEMen=1 and MEMaddr/MEMdin/MEMwe are driven from the latched values.
  - If cnt==0: on a read, capture MEMdout into the owner's read register, then go to DONE.
  - Otherwise decrement cnt.
- DONE: pulse ACKcpu or DONEdma for the owner, then return to IDLE. There is no back-to-back grant from DONE.
- Read registers:
  - Each holds its value until the next read by the same owner.
  - A write access does not modify either register.
- DMA handshake:
  - GNTdma rises in the cycle after grant and stays high through DONE.
  - If REQdma drops before grant, nothing happens.
  - If REQdma drops after grant, the access still completes.
- Latched address and data are immune to input changes after grant.
- Reset values: state=IDLE, cnt=0, starve_cnt=0, DOUTcpu=0, DOUTdma=0, owner=CPU.
  - All registered outputs are 0: ACKcpu, GNTdma, DONEdma, MEMen, MEMwe, MEMaddr, MEMdin.
  - STALL follows its equation.
- RST mid-access aborts the access:
  - MEMen is 0 in the cycle after the RST edge.
  - No ACK or DONE pulse is issued for the aborted access.

## Timing
- Grant cycle t: the IDLE cycle with a selected request.
- ACCESS occupies cycles t+1 .. t+1+WAIT; MEMdout is sampled at the end of t+1+WAIT.
- DONE is cycle t+2+WAIT, where ACKcpu/DONEdma=1 and read data is valid.
- Latency:
  - From an idle bus, request to ACK is WAIT+2 cycles.
  - The bus is occupied for WAIT+3 cycles per access.
- STALL:
  - High from the first cycle of the CPU request through t+1+WAIT.
  - Low in the DONE cycle, so PC advances on the edge ending DONE.
- Simultaneous CPU and DMA requests in IDLE: the CPU wins unless starve_cnt==STARVE.
- A request arriving during ACCESS or DONE waits for IDLE. There is no preemption.
- WAIT=0: MEMen is high for exactly 1 cycle, and ACK comes 2 cycles after grant.

## Test plan
- Reset, then idle with WAIT=1 -> all outputs 0 and STALL=0. Raise Rbus, ADDRcpu=0x0010, memory returns 0xBEEF -> MEMen high for 2 cycles, ACKcpu pulse 3 cycles after Rbus, DOUTcpu=0xBEEF, STALL high for exactly 3 cycles.
- CPU write with Wbus=Rbus=1, ADDRcpu=0x0020, DINcpu=0x1234 -> MEMwe=1 for both MEMen cycles, MEMaddr=0x0020, MEMdin=0x1234, DOUTcpu unchanged.
- DMA read with CPU idle, ADDRdma=0x0100, memory 0x00AA -> GNTdma high for 3 cycles, DONEdma in the last of them, DOUTdma=0x00AA.
- Starvation with STARVE=4: CPU requests continuously and REQdma held -> exactly 4 CPU ACKs, then one DMA grant, then CPU resumes. The counter restarts from 0.
- RST asserted during the second ACCESS cycle of a DMA write -> next cycle MEMen=0 and GNTdma=0, no DONEdma. After RST release with REQdma still high, a fresh grant follows.
- WAIT=0 with a DMA request raised during a CPU access -> DMA is granted in the first IDLE after the CPU DONE, and the CPU address and data latched at grant are unaffected by the DMA inputs.
